// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction queue between IF1 and decode.
// Optional INST_QUEUE_PERF_EN adds saturating full/empty cycle counters.
module inst_queue #(
  parameter int DEPTH        = 8,
  parameter int LOG_DEPTH    = 3,
  parameter int SPACE_THRESH = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        fifo_readygo,
  output logic        fifo_allowin,
  output logic        space_ok,
  output logic        nearly_full,
  input  logic [31:0] if1_fifo_pc,
  input  logic [31:0] if1_fifo_pc_next,
  input  logic        if1_fifo_pc_taken,
  input  logic [31:0] if1_fifo_inst0,
  input  logic [31:0] if1_fifo_inst1,
  input  logic [31:0] if1_fifo_icache_badv,
  input  logic [6:0]  if1_fifo_icache_exception,
  input  logic [1:0]  if1_fifo_icache_excp_flag,
  input  logic [1:0]  iq_pop_cnt,
  output logic [1:0]  iq_valid,
  output logic [31:0] iq_pc0,
  output logic [31:0] iq_pc1,
  output logic [31:0] iq_pc_next0,
  output logic [31:0] iq_pc_next1,
  output logic [31:0] iq_inst0,
  output logic [31:0] iq_inst1,
  output logic        iq_taken0,
  output logic        iq_taken1,
  output logic        iq_excp0,
  output logic        iq_excp1,
  output logic [31:0] iq_badv,
  output logic [6:0]  iq_exception
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0] iq_full_cycles,
  output logic [31:0] iq_empty_cycles
`endif
);

  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);

  logic [31:0]        r_pc      [DEPTH];
  logic [31:0]        r_pc_next [DEPTH];
  logic [31:0]        r_inst    [DEPTH];
  logic [31:0]        r_badv    [DEPTH];
  logic [6:0]         r_exc     [DEPTH];
  logic               r_taken   [DEPTH];
  logic               r_excp    [DEPTH];

  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH:0]   r_count;

  logic [LOG_DEPTH:0]   w_free;
  logic                 w_push;
  logic                 w_single;
  logic [LOG_DEPTH:0]   w_push_n;
  logic [LOG_DEPTH:0]   w_pop_req;
  logic [LOG_DEPTH:0]   w_pop_k;
  logic [LOG_DEPTH-1:0] w_wr_ptr1;
  logic [LOG_DEPTH-1:0] w_rd_ptr1;
  logic [31:0]          w_pc_plus4;

  // Back-pressure looks only at the registered count; same-cycle pops are not credited.
  assign w_free       = (LOG_DEPTH+1)'(DEPTH) - r_count;
  assign fifo_allowin = (w_free >= (LOG_DEPTH+1)'(2));
  assign space_ok     = (w_free >= (LOG_DEPTH+1)'(SPACE_THRESH));
  assign nearly_full  = fifo_allowin && !space_ok;

  assign w_push     = fifo_readygo && fifo_allowin;
  assign w_single   = if1_fifo_pc[2];
  assign w_push_n   = !w_push ? '0 : (w_single ? (LOG_DEPTH+1)'(1) : (LOG_DEPTH+1)'(2));
  assign w_pop_req  = (LOG_DEPTH+1)'(iq_pop_cnt);
  assign w_pop_k    = (w_pop_req > r_count) ? r_count : w_pop_req;
  assign w_wr_ptr1  = r_wr_ptr + PTR_ONE;
  assign w_rd_ptr1  = r_rd_ptr + PTR_ONE;
  assign w_pc_plus4 = if1_fifo_pc + 32'd4;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_n[LOG_DEPTH-1:0];
      r_rd_ptr <= r_rd_ptr + w_pop_k[LOG_DEPTH-1:0];
      r_count  <= r_count + w_push_n - w_pop_k;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]      <= if1_fifo_pc;
      r_inst[r_wr_ptr]    <= if1_fifo_inst0;
      r_excp[r_wr_ptr]    <= if1_fifo_icache_excp_flag[0];
      r_badv[r_wr_ptr]    <= if1_fifo_icache_badv;
      r_exc[r_wr_ptr]     <= if1_fifo_icache_exception;
      r_pc_next[r_wr_ptr] <= w_single ? if1_fifo_pc_next : w_pc_plus4;
      r_taken[r_wr_ptr]   <= w_single ? if1_fifo_pc_taken : 1'b0;
      if (!w_single) begin
        r_pc[w_wr_ptr1]      <= w_pc_plus4;
        r_inst[w_wr_ptr1]    <= if1_fifo_inst1;
        r_excp[w_wr_ptr1]    <= if1_fifo_icache_excp_flag[1];
        r_badv[w_wr_ptr1]    <= if1_fifo_icache_badv;
        r_exc[w_wr_ptr1]     <= if1_fifo_icache_exception;
        r_pc_next[w_wr_ptr1] <= if1_fifo_pc_next;
        r_taken[w_wr_ptr1]   <= if1_fifo_pc_taken;
      end
    end
  end

  always_comb begin
    iq_valid     = {(r_count >= (LOG_DEPTH+1)'(2)), (r_count != '0)};
    iq_pc0       = 32'd0;
    iq_pc_next0  = 32'd4;
    iq_inst0     = INST_NOP;
    iq_taken0    = 1'b0;
    iq_excp0     = 1'b0;
    iq_pc1       = 32'd0;
    iq_pc_next1  = 32'd4;
    iq_inst1     = INST_NOP;
    iq_taken1    = 1'b0;
    iq_excp1     = 1'b0;
    iq_badv      = 32'd0;
    iq_exception = 7'd0;
    if (iq_valid[0]) begin
      iq_pc0      = r_pc[r_rd_ptr];
      iq_pc_next0 = r_pc_next[r_rd_ptr];
      iq_inst0    = r_inst[r_rd_ptr];
      iq_taken0   = r_taken[r_rd_ptr];
      iq_excp0    = r_excp[r_rd_ptr];
    end
    if (iq_valid[1]) begin
      iq_pc1      = r_pc[w_rd_ptr1];
      iq_pc_next1 = r_pc_next[w_rd_ptr1];
      iq_inst1    = r_inst[w_rd_ptr1];
      iq_taken1   = r_taken[w_rd_ptr1];
      iq_excp1    = r_excp[w_rd_ptr1];
    end
    if (iq_excp0) begin
      iq_badv      = r_badv[r_rd_ptr];
      iq_exception = r_exc[r_rd_ptr];
    end else if (iq_excp1) begin
      iq_badv      = r_badv[w_rd_ptr1];
      iq_exception = r_exc[w_rd_ptr1];
    end
  end

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] r_full_cycles;
  logic [31:0] r_empty_cycles;

  // Only reset clears these; flush leaves the statistics intact.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full_cycles  <= '0;
      r_empty_cycles <= '0;
    end else begin
      if (fifo_readygo && !fifo_allowin && (r_full_cycles != '1))
        r_full_cycles <= r_full_cycles + 32'd1;
      if ((r_count == '0) && (r_empty_cycles != '1))
        r_empty_cycles <= r_empty_cycles + 32'd1;
    end
  end

  assign iq_full_cycles  = r_full_cycles;
  assign iq_empty_cycles = r_empty_cycles;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue (DEPTH=8).
module tb_inst_queue;

  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        fifo_readygo;
  logic        fifo_allowin;
  logic        space_ok;
  logic        nearly_full;
  logic [31:0] if1_fifo_pc;
  logic [31:0] if1_fifo_pc_next;
  logic        if1_fifo_pc_taken;
  logic [31:0] if1_fifo_inst0;
  logic [31:0] if1_fifo_inst1;
  logic [31:0] if1_fifo_icache_badv;
  logic [6:0]  if1_fifo_icache_exception;
  logic [1:0]  if1_fifo_icache_excp_flag;
  logic [1:0]  iq_pop_cnt;
  logic [1:0]  iq_valid;
  logic [31:0] iq_pc0, iq_pc1, iq_pc_next0, iq_pc_next1, iq_inst0, iq_inst1;
  logic        iq_taken0, iq_taken1, iq_excp0, iq_excp1;
  logic [31:0] iq_badv;
  logic [6:0]  iq_exception;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .fifo_readygo(fifo_readygo), .fifo_allowin(fifo_allowin),
    .space_ok(space_ok), .nearly_full(nearly_full),
    .if1_fifo_pc(if1_fifo_pc), .if1_fifo_pc_next(if1_fifo_pc_next),
    .if1_fifo_pc_taken(if1_fifo_pc_taken),
    .if1_fifo_inst0(if1_fifo_inst0), .if1_fifo_inst1(if1_fifo_inst1),
    .if1_fifo_icache_badv(if1_fifo_icache_badv),
    .if1_fifo_icache_exception(if1_fifo_icache_exception),
    .if1_fifo_icache_excp_flag(if1_fifo_icache_excp_flag),
    .iq_pop_cnt(iq_pop_cnt), .iq_valid(iq_valid),
    .iq_pc0(iq_pc0), .iq_pc1(iq_pc1),
    .iq_pc_next0(iq_pc_next0), .iq_pc_next1(iq_pc_next1),
    .iq_inst0(iq_inst0), .iq_inst1(iq_inst1),
    .iq_taken0(iq_taken0), .iq_taken1(iq_taken1),
    .iq_excp0(iq_excp0), .iq_excp1(iq_excp1),
    .iq_badv(iq_badv), .iq_exception(iq_exception)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic go, input logic [31:0] pc, input logic [31:0] pcn,
                         input logic tk, input logic [1:0] ef);
    fifo_readygo              = go;
    if1_fifo_pc               = pc;
    if1_fifo_pc_next          = pcn;
    if1_fifo_pc_taken         = tk;
    if1_fifo_inst0            = pc ^ 32'hA000_0000;
    if1_fifo_inst1            = (pc + 32'd4) ^ 32'hA000_0000;
    if1_fifo_icache_excp_flag = ef;
  endtask

  task automatic push2(input logic [31:0] pc);
    set_pkt(1'b1, pc, pc + 32'd8, 1'b0, 2'b00);
    tick();
    fifo_readygo = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; iq_pop_cnt = 2'd0;
    if1_fifo_icache_badv = 32'd0; if1_fifo_icache_exception = 7'd0;
    set_pkt(1'b0, 32'd0, 32'd0, 1'b0, 2'b00);
    #12;
    chk("rst_valid", 32'(iq_valid), 32'h0);
    chk("rst_allowin", 32'(fifo_allowin), 32'h1);
    chk("rst_space_ok", 32'(space_ok), 32'h1);
    chk("rst_nearly_full", 32'(nearly_full), 32'h0);
    chk("rst_pc0", iq_pc0, 32'h0);
    chk("rst_pc_next0", iq_pc_next0, 32'h4);
    chk("rst_inst0", iq_inst0, NOP);
    rstn = 1'b1;
    tick();

    // Two-instruction packet
    set_pkt(1'b1, 32'h1c00_0000, 32'h1c00_0008, 1'b0, 2'b00);
    tick();
    fifo_readygo = 1'b0;
    chk("p2_valid", 32'(iq_valid), 32'h3);
    chk("p2_pc0", iq_pc0, 32'h1c00_0000);
    chk("p2_pc1", iq_pc1, 32'h1c00_0004);
    chk("p2_pc_next0", iq_pc_next0, 32'h1c00_0004);
    chk("p2_pc_next1", iq_pc_next1, 32'h1c00_0008);
    chk("p2_inst1", iq_inst1, 32'hBC00_0004);
    chk("p2_count", 32'(dut.r_count), 32'd2);

    // Pop both while pushing a single taken instruction
    set_pkt(1'b1, 32'h1c00_0004, 32'h1c00_0100, 1'b1, 2'b00);
    iq_pop_cnt = 2'd2;
    tick();
    fifo_readygo = 1'b0; iq_pop_cnt = 2'd0;
    chk("p1_valid", 32'(iq_valid), 32'h1);
    chk("p1_pc0", iq_pc0, 32'h1c00_0004);
    chk("p1_pc_next0", iq_pc_next0, 32'h1c00_0100);
    chk("p1_taken0", 32'(iq_taken0), 32'h1);
    chk("p1_pc_next1", iq_pc_next1, 32'h4);
    chk("p1_inst1", iq_inst1, NOP);

    iq_pop_cnt = 2'd1;
    tick();
    iq_pop_cnt = 2'd0;
    chk("empty_valid", 32'(iq_valid), 32'h0);

    // Fill: rd = wr = 3, four 2-entry packets wrap the write pointer
    push2(32'h1c00_0010);
    chk("f1_space_ok", 32'(space_ok), 32'h1);
    push2(32'h1c00_0018);
    chk("f2_space_ok", 32'(space_ok), 32'h0);
    chk("f2_nearly_full", 32'(nearly_full), 32'h1);
    push2(32'h1c00_0020);
    chk("f3_allowin", 32'(fifo_allowin), 32'h1);
    push2(32'h1c00_0028);
    chk("f4_allowin", 32'(fifo_allowin), 32'h0);
    chk("f4_nearly_full", 32'(nearly_full), 32'h0);
    chk("f4_count", 32'(dut.r_count), 32'd8);
    push2(32'h1c00_0030);
    chk("f5_ignored_count", 32'(dut.r_count), 32'd8);
    chk("f5_pc0", iq_pc0, 32'h1c00_0010);

    iq_pop_cnt = 2'd2;
    tick();
    iq_pop_cnt = 2'd0;
    set_pkt(1'b1, 32'h1c00_0034, 32'h1c00_0038, 1'b0, 2'b00);
    tick();
    fifo_readygo = 1'b0;
    chk("c7_count", 32'(dut.r_count), 32'd7);
    chk("c7_rd_ptr", 32'(dut.r_rd_ptr), 32'd5);
    chk("c7_pc0", iq_pc0, 32'h1c00_0018);
    chk("c7_allowin", 32'(fifo_allowin), 32'h0);

    // Push refused at free = 1 while popping two
    set_pkt(1'b1, 32'h1c00_0040, 32'h1c00_0048, 1'b0, 2'b00);
    iq_pop_cnt = 2'd2;
    tick();
    fifo_readygo = 1'b0; iq_pop_cnt = 2'd0;
    chk("c5_count", 32'(dut.r_count), 32'd5);
    chk("c5_pc0", iq_pc0, 32'h1c00_0020);
    chk("c5_pc1_wrap", iq_pc1, 32'h1c00_0024);
    chk("c5_inst1_wrap", iq_inst1, 32'hBC00_0024);

    iq_pop_cnt = 2'd2;
    tick();
    chk("c3_pc0", iq_pc0, 32'h1c00_0028);
    chk("c3_pc1", iq_pc1, 32'h1c00_002c);
    tick();
    chk("c1_valid", 32'(iq_valid), 32'h1);
    chk("c1_pc0", iq_pc0, 32'h1c00_0034);
    chk("c1_pc_next0", iq_pc_next0, 32'h1c00_0038);
    tick();
    iq_pop_cnt = 2'd0;
    chk("excess_pop_count", 32'(dut.r_count), 32'd0);
    chk("excess_pop_valid", 32'(iq_valid), 32'h0);

    // Exception on the second instruction of a packet
    if1_fifo_icache_badv = 32'h1c00_0ffc; if1_fifo_icache_exception = 7'h08;
    set_pkt(1'b1, 32'h1c00_0ff8, 32'h1c00_1000, 1'b0, 2'b10);
    tick();
    fifo_readygo = 1'b0;
    chk("ex_excp0", 32'(iq_excp0), 32'h0);
    chk("ex_excp1", 32'(iq_excp1), 32'h1);
    chk("ex_badv", iq_badv, 32'h1c00_0ffc);
    chk("ex_code", 32'(iq_exception), 32'h08);
    iq_pop_cnt = 2'd1;
    tick();
    chk("ex_pop_excp0", 32'(iq_excp0), 32'h1);
    chk("ex_pop_badv", iq_badv, 32'h1c00_0ffc);
    tick();
    iq_pop_cnt = 2'd0;
    chk("ex_empty_badv", iq_badv, 32'h0);
    chk("ex_empty_code", 32'(iq_exception), 32'h0);
    if1_fifo_icache_badv = 32'd0; if1_fifo_icache_exception = 7'd0;

    // Flush beats simultaneous push and pop
    push2(32'h1c00_1000);
    push2(32'h1c00_1008);
    chk("fl_pre_count", 32'(dut.r_count), 32'd4);
    set_pkt(1'b1, 32'h1c00_1010, 32'h1c00_1018, 1'b0, 2'b00);
    iq_pop_cnt = 2'd2; flush = 1'b1;
    tick();
    fifo_readygo = 1'b0; iq_pop_cnt = 2'd0; flush = 1'b0;
    chk("fl_count", 32'(dut.r_count), 32'd0);
    chk("fl_valid", 32'(iq_valid), 32'h0);
    chk("fl_allowin", 32'(fifo_allowin), 32'h1);

    // Asynchronous reset mid-cycle, then first push after release
    push2(32'h1c00_1020);
    #2;
    rstn = 1'b0;
    #2;
    chk("ar_count", 32'(dut.r_count), 32'd0);
    chk("ar_valid", 32'(iq_valid), 32'h0);
    set_pkt(1'b1, 32'h1c00_2000, 32'h1c00_2008, 1'b0, 2'b00);
    #1;
    rstn = 1'b1;
    tick();
    fifo_readygo = 1'b0;
    chk("ar_push_valid", 32'(iq_valid), 32'h3);
    chk("ar_push_pc0", iq_pc0, 32'h1c00_2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
